pwm_fade_ctrl: RTL



---
 rtl/pwm_fade_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for a bank of PWM compare registers: every TICK_DIV PWM periods
// it sweeps the channels one per clock, moving each duty toward its target by one step.
module pwm_fade_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int CTR_LEN  = 8,
  parameter int TICK_DIV = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      period_start,
  input  logic                      wr_en,
  output logic                      wr_ready,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [CTR_LEN-1:0]        wr_target,
  input  logic [CTR_LEN-1:0]        wr_step,
  output logic [NUM_CH*CTR_LEN-1:0] compare,
  output logic [NUM_CH-1:0]         settled,
  output logic                      ovr
);

  typedef enum logic {IDLE, UPDATE} state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CH_W-1:0]  IDX_LAST  = CH_W'(NUM_CH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CH_W-1:0]  r_idx;
  logic [CH_W-1:0]  w_idx_next;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             r_ovr;
  logic             w_tick;
  logic             w_wr_acc;

  // The extra bit keeps cur+step from wrapping past the top of the duty range.
  function automatic logic [CTR_LEN-1:0] f_step_toward(
    input logic [CTR_LEN-1:0] cur,
    input logic [CTR_LEN-1:0] tgt,
    input logic [CTR_LEN-1:0] stp
  );
    logic [CTR_LEN:0] sum;
    logic [CTR_LEN:0] gap;
    f_step_toward = cur;
    sum = {1'b0, cur} + {1'b0, stp};
    gap = {1'b0, cur} - {1'b0, tgt};
    if (cur < tgt) begin
      f_step_toward = (sum >= {1'b0, tgt}) ? tgt : sum[CTR_LEN-1:0];
    end else if (cur > tgt) begin
      f_step_toward = ({1'b0, stp} >= gap) ? tgt : (cur - stp);
    end
  endfunction

  assign w_tick   = period_start && (r_tick_cnt == TICK_LAST);
  assign wr_ready = (r_state == IDLE);
  assign w_wr_acc = wr_en && wr_ready;
  assign ovr      = r_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_tick_cnt <= '0;
      r_ovr      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (period_start) begin
        r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
      end
      if (w_tick && (r_state == UPDATE)) begin
        r_ovr <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_next = UPDATE;
          w_idx_next   = '0;
        end
      end
      UPDATE: begin
        if (r_idx == IDX_LAST) begin
          w_state_next = IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Writes only land in IDLE and updates only in UPDATE, so the two never collide.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CTR_LEN-1:0] r_cur;
      logic [CTR_LEN-1:0] r_target;
      logic [CTR_LEN-1:0] r_step;
      logic               r_settled;
      logic [CTR_LEN-1:0] w_cur_next;
      logic               w_sel_wr;
      logic               w_sel_upd;

      assign w_cur_next = f_step_toward(r_cur, r_target, r_step);
      assign w_sel_wr   = w_wr_acc && (wr_ch == CH_W'(gi));
      assign w_sel_upd  = (r_state == UPDATE) && (r_idx == CH_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cur     <= '0;
          r_target  <= '0;
          r_step    <= '0;
          r_settled <= 1'b1;
        end else if (w_sel_wr) begin
          r_target  <= wr_target;
          r_step    <= wr_step;
          r_settled <= (r_cur == wr_target);
        end else if (w_sel_upd) begin
          r_cur     <= w_cur_next;
          r_settled <= (w_cur_next == r_target);
        end
      end

      assign compare[gi*CTR_LEN +: CTR_LEN] = r_cur;
      assign settled[gi]                    = r_settled;
    end
  endgenerate

endmodule
